// File: rtl/key_event_fsm_pkg.sv
// Shared types and default timing for the key event classifier.
package key_event_fsm_pkg;

  // Binary state encoding, 3 bits.
  typedef enum logic [2:0] {
    IDLE           = 3'd0,
    PRESSED        = 3'd1,
    LONG_HELD      = 3'd2,
    WAIT_SECOND    = 3'd3,
    SECOND_PRESSED = 3'd4
  } key_state_e;

  // Default timing at 100 MHz.
  localparam int LONG_CNT_DEF   = 100_000_000;
  localparam int DCLICK_CNT_DEF = 25_000_000;
  localparam int REPEAT_CNT_DEF = 20_000_000;

  // Largest of three timing constants, used to size the shared counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/key_event_fsm_edge_det.sv
// Press/release edge detector on the debounced key level (idle high).
// key_d resets high so a key held low across reset reads as a fresh press.
module key_edge_det (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic key_filter,
  output logic key_press,
  output logic key_release
);

  logic key_d;

  // Previous-sample register.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) key_d <= 1'b1;
    else         key_d <= key_filter;
  end

  assign key_press   =  key_d & ~key_filter;
  assign key_release = ~key_d &  key_filter;

endmodule

// File: rtl/key_event_fsm.sv
// Key action classifier: short press, long press, double click, one
// registered single-cycle pulse per action.
// Optional auto-repeat while long-held: define KEY_EVENT_REPEAT_EN.
module key_event_fsm
  import key_event_fsm_pkg::*;
#(
  parameter int LONG_CNT   = LONG_CNT_DEF,
  parameter int DCLICK_CNT = DCLICK_CNT_DEF,
  parameter int REPEAT_CNT = REPEAT_CNT_DEF
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic key_filter,
  output logic short_press,
  output logic long_press,
  output logic double_click,
  output logic repeat_pulse,
  output logic key_busy
);

  localparam int CNT_W = $clog2(max3(LONG_CNT, DCLICK_CNT, REPEAT_CNT)) + 1;
  localparam logic [CNT_W-1:0] LONG_TC   = CNT_W'(LONG_CNT - 1);
  localparam logic [CNT_W-1:0] DCLICK_TC = CNT_W'(DCLICK_CNT - 1);

  logic key_press, key_release;

  key_edge_det u_edge (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .key_filter  (key_filter),
    .key_press   (key_press),
    .key_release (key_release)
  );

  key_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             short_d, long_d, dclick_d;

  // State, counter and event registers; busy tracks the next state so it
  // lines up with the registered state.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      double_click <= 1'b0;
      key_busy     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      short_press  <= short_d;
      long_press   <= long_d;
      double_click <= dclick_d;
      key_busy     <= (state_d != IDLE);
    end
  end

`ifdef KEY_EVENT_REPEAT_EN
  localparam logic [CNT_W-1:0] REPEAT_TC = CNT_W'(REPEAT_CNT - 1);
  logic rep_d;

  // Repeat pulse register.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) repeat_pulse <= 1'b0;
    else         repeat_pulse <= rep_d;
  end
`else
  assign repeat_pulse = 1'b0;
`endif

  // Next-state, counter and event decode. Every counting state leaves at
  // its terminal count, so the counter never wraps.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    short_d  = 1'b0;
    long_d   = 1'b0;
    dclick_d = 1'b0;
`ifdef KEY_EVENT_REPEAT_EN
    rep_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        // A stray release here is ignored.
        if (key_press) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end
      end
      PRESSED: begin
        // Release takes priority: the key is no longer low at terminal count.
        if (key_release) begin
          state_d = WAIT_SECOND;
          cnt_d   = '0;
        end else if (cnt_q == LONG_TC) begin
          long_d  = 1'b1;
          state_d = LONG_HELD;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + 1'b1;
        end
      end
      LONG_HELD: begin
        if (key_release) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
`ifdef KEY_EVENT_REPEAT_EN
        else if (cnt_q == REPEAT_TC) begin
          rep_d   = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + 1'b1;
        end
`endif
      end
      WAIT_SECOND: begin
        // A press on the timeout cycle still counts as a double click.
        if (key_press) begin
          state_d = SECOND_PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == DCLICK_TC) begin
          short_d = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + 1'b1;
        end
      end
      SECOND_PRESSED: begin
        // Hold time of the second press is irrelevant.
        if (key_release) begin
          dclick_d = 1'b1;
          state_d  = IDLE;
          cnt_d    = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule
